bitcoin_nonce_search: RTL and testbench
=======================================

# bitcoin_nonce_search

Parametrised successor to the fixed 16-nonce Bitcoin hasher. It reads a 19-word block header from shared memory and computes the first-block midstate once. It then sweeps a configurable nonce range, running the double SHA-256 (block 2 plus final hash) for each nonce, and writes word H0 of every final digest back to memory. An optional compile-time target comparator adds early exit on the first nonce whose H0 falls below a runtime target. The block sits on the single-port memory bus beside the other hash engines.

## Interface
- NUM_NONCES, 16, number of nonces swept; legal range 1..65535
- NONCE_BASE, 32'h0, first nonce value
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request; honoured only in IDLE or DONE
- message_addr  in  16  base address of the 19 header words
- output_addr  in  16  base address of the result words
- target  in  32  unsigned threshold for the target comparator; ignored without the macro
- mem_read_data  in  32  memory read data, valid one cycle after its address
- done  out  1  high in DONE until the next accepted start
- found  out  1  a qualifying nonce has been seen
- found_nonce  out  32  first qualifying nonce
- mem_clk  out  1  equals clk
- mem_we  out  1  write strobe
- mem_addr  out  16  memory address
- mem_write_data  out  32  write data

## Operation
- States: IDLE, READ, BLK1, FIN1, BLK2, FIN2, BLK3, FIN3, WR, DONE.
- IDLE/DONE + start: clear done, found, found_nonce, nonce index i=0, rc=0; go to READ.
- READ: issue message_addr+0..18 on consecutive cycles and capture each word one cycle later. Words 0..15 fill the schedule; words 16..18 go to buf[0..2]. 20 cycles, then BLK1 with a..h = SHA-256 IV.
- BLK1: 64 rounds, one round per cycle, using the rolling 16-entry schedule (w[t] for t≥16 from σ0/σ1).
- FIN1: midstate M = IV + a..h. Load a..h = M.
- BLK2: message is buf[0], buf[1], buf[2], NONCE_BASE+i, 32'h80000000, 10 × 0, 32'd640.
- FIN2: D = M + a..h. Load a..h = IV.
- BLK3: message is D0..D7, 32'h80000000, 6 × 0, 32'd256.
- FIN3: H = IV + a..h.
- WR: for exactly one cycle, mem_we=1, mem_addr=output_addr+i (16-bit wrap), mem_write_data=H0.
  - If i==NUM_NONCES-1, or an early exit applies (see Configuration), go to DONE.
  - Otherwise i++, load a..h = M, and go to BLK2.
- Arithmetic: all sums are mod 2^32. Nonce = NONCE_BASE+i mod 2^32, so 32'hFFFFFFFF is followed by 0.
- mem_we is 0 in every state except WR.
- reset_n low, even mid-operation, immediately forces:
  - state IDLE;
  - done, found, mem_we = 0;
  - found_nonce, mem_addr, mem_write_data = 0.
  No write is issued after release until a new start is accepted.

## Timing
- The cycle in which start is sampled is cycle 0. The first memory address is driven on cycle 1.
- Header fetch plus block 1 take 85 cycles (READ 20, BLK1 64, FIN1 1).
- Each nonce takes 131 cycles (BLK2 64, FIN2 1, BLK3 64, FIN3 1, WR 1).
- done rises at cycle 86 + 131·(number of nonces processed); this is cycle 2182 for 16 nonces.
- The write for nonce i occurs on cycle 85 + 131·(i+1).
- start while busy is ignored.

## Configuration
- Macro BTC_TARGET_SEARCH_EN.
- Defined:
  - In FIN3, compare H0 against target using strict unsigned less-than (H0 < target).
  - On the first hit, set found=1 and found_nonce=NONCE_BASE+i. Both hold until the next start or reset.
  - The WR for the hit is still performed, then the block goes to DONE (early exit).
- Undefined:
  - Comparator absent; found and found_nonce stay 0 and target is unused.
  - All NUM_NONCES nonces are processed.

## Test plan
- NUM_NONCES=16, NONCE_BASE=0, standard 19-word header at 0x0000, output_addr=0x0100 -> 16 single-cycle writes to 0x0100..0x010F, each matching the software double-SHA-256 model; done at cycle 2182; mem_we never high outside WR.
- NUM_NONCES=2, NONCE_BASE=32'hFFFFFFFF, output_addr=0xFFFF -> nonces FFFFFFFF then 00000000; writes to 0xFFFF then 0x0000; both hashes match the model.
- Assert reset_n during BLK2 of nonce 3 -> all outputs return to 0 at once and no further writes occur; a fresh start produces results identical to the first test.
- Pulse start at cycle 500 of a run -> ignored; write count and done cycle unchanged. start in DONE -> done clears next cycle and a new run begins.
- Macro defined, target=32'hFFFFFFFF -> found=1 and found_nonce=NONCE_BASE after nonce 0; one write; done at cycle 217.
- Macro defined, target=0 -> found stays 0; all 16 writes; done at 2182. Macro undefined with any target -> found and found_nonce stay 0.

Source files
------------

// File: rtl/bitcoin_nonce_search.sv
// rtl/bitcoin_nonce_search.sv - double SHA-256 nonce sweep over a 19-word header on a single-port memory bus
// Optional target comparator with early exit is enabled by defining BTC_TARGET_SEARCH_EN.
module bitcoin_nonce_search #(
  parameter int          NUM_NONCES = 16,
  parameter logic [31:0] NONCE_BASE = 32'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] message_addr,
  input  logic [15:0] output_addr,
  input  logic [31:0] target,
  input  logic [31:0] mem_read_data,
  output logic        done,
  output logic        found,
  output logic [31:0] found_nonce,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data
);

  typedef enum logic [3:0] {
    S_IDLE, S_READ, S_BLK1, S_FIN1, S_BLK2, S_FIN2, S_BLK3, S_FIN3, S_WR, S_DONE
  } state_t;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [15:0] LAST_IDX = 16'(NUM_NONCES - 1);

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  state_t      state_q, state_d;
  logic [5:0]  rc_q, rc_d;
  logic [15:0] idx_q, idx_d;
  logic        found_q, found_d;
  logic [31:0] found_nonce_q, found_nonce_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] st_q [8];
  logic [31:0] st_d [8];
  logic [31:0] mid_q [8];
  logic [31:0] mid_d [8];
  logic [31:0] w_q [16];
  logic [31:0] w_d [16];
  logic [31:0] hdr_q [3];
  logic [31:0] hdr_d [3];

  logic [31:0] t1, t2, w_new, nonce, nonce_ld, h0;
  logic        last, exit_now, load_blk2;

  assign last  = (idx_q == LAST_IDX);
  assign nonce = NONCE_BASE + {16'h0, idx_q};
  assign h0    = IV[0] + st_q[0];

`ifdef BTC_TARGET_SEARCH_EN
  assign exit_now = last | found_q;
`else
  logic unused_target;
  assign exit_now      = last;
  assign unused_target = ^target;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      rc_q          <= '0;
      idx_q         <= '0;
      found_q       <= 1'b0;
      found_nonce_q <= '0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      rc_q          <= rc_d;
      idx_q         <= idx_d;
      found_q       <= found_d;
      found_nonce_q <= found_nonce_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    st_q  <= st_d;
    mid_q <= mid_d;
    w_q   <= w_d;
    hdr_q <= hdr_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_READ;
      S_READ:         if (rc_q == 6'd19) state_d = S_BLK1;
      S_BLK1:         if (rc_q == 6'd63) state_d = S_FIN1;
      S_FIN1:         state_d = S_BLK2;
      S_BLK2:         if (rc_q == 6'd63) state_d = S_FIN2;
      S_FIN2:         state_d = S_BLK3;
      S_BLK3:         if (rc_q == 6'd63) state_d = S_FIN3;
      S_FIN3:         state_d = S_WR;
      S_WR:           state_d = exit_now ? S_DONE : S_BLK2;
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    done           = (state_q == S_DONE);
    found          = found_q;
    found_nonce    = found_nonce_q;
    mem_clk        = clk;
    mem_we         = mem_we_q;
    mem_addr       = mem_addr_q;
    mem_write_data = mem_wdata_q;
  end

  always_comb begin
    st_d          = st_q;
    mid_d         = mid_q;
    w_d           = w_q;
    hdr_d         = hdr_q;
    rc_d          = rc_q;
    idx_d         = idx_q;
    found_d       = found_q;
    found_nonce_d = found_nonce_q;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    load_blk2     = 1'b0;

    t1 = st_q[7] + (rotr(st_q[4], 6) ^ rotr(st_q[4], 11) ^ rotr(st_q[4], 25))
       + ((st_q[4] & st_q[5]) ^ (~st_q[4] & st_q[6])) + K[rc_q] + w_q[0];
    t2 = (rotr(st_q[0], 2) ^ rotr(st_q[0], 13) ^ rotr(st_q[0], 22))
       + ((st_q[0] & st_q[1]) ^ (st_q[0] & st_q[2]) ^ (st_q[1] & st_q[2]));
    w_new = (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10)) + w_q[9]
          + (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3)) + w_q[0];

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          found_d       = 1'b0;
          found_nonce_d = '0;
          idx_d         = '0;
          rc_d          = '0;
          mem_addr_d    = message_addr;
        end
      end
      S_READ: begin
        // read data lags the address by one cycle, so rc counts captures one behind
        rc_d       = (rc_q == 6'd19) ? 6'd0 : rc_q + 6'd1;
        mem_addr_d = message_addr + {10'h0, rc_q} + 16'd1;
        if (rc_q >= 6'd1 && rc_q <= 6'd16) begin
          for (int k = 0; k < 15; k++) w_d[k] = w_q[k+1];
          w_d[15] = mem_read_data;
        end
        case (rc_q)
          6'd17:   hdr_d[0] = mem_read_data;
          6'd18:   hdr_d[1] = mem_read_data;
          6'd19:   hdr_d[2] = mem_read_data;
          default: ;
        endcase
        if (rc_q == 6'd19) st_d = IV;
      end
      S_BLK1, S_BLK2, S_BLK3: begin
        rc_d  = rc_q + 6'd1;
        st_d  = '{t1 + t2, st_q[0], st_q[1], st_q[2], st_q[3] + t1, st_q[4], st_q[5], st_q[6]};
        for (int k = 0; k < 15; k++) w_d[k] = w_q[k+1];
        w_d[15] = w_new;
      end
      S_FIN1: begin
        for (int k = 0; k < 8; k++) begin
          mid_d[k] = IV[k] + st_q[k];
          st_d[k]  = IV[k] + st_q[k];
        end
        load_blk2 = 1'b1;
      end
      S_FIN2: begin
        for (int k = 0; k < 8; k++) w_d[k] = mid_q[k] + st_q[k];
        for (int k = 9; k < 15; k++) w_d[k] = '0;
        w_d[8]  = 32'h80000000;
        w_d[15] = 32'd256;
        st_d    = IV;
      end
      S_FIN3: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = output_addr + idx_q;
        mem_wdata_d = h0;
`ifdef BTC_TARGET_SEARCH_EN
        if (!found_q && (h0 < target)) begin
          found_d       = 1'b1;
          found_nonce_d = nonce;
        end
`endif
      end
      S_WR: begin
        if (!exit_now) begin
          idx_d     = idx_q + 16'd1;
          st_d      = mid_q;
          load_blk2 = 1'b1;
        end
      end
      default: ;
    endcase

    nonce_ld = NONCE_BASE + {16'h0, idx_d};
    if (load_blk2) begin
      for (int k = 0; k < 16; k++) w_d[k] = '0;
      w_d[0]  = hdr_d[0];
      w_d[1]  = hdr_d[1];
      w_d[2]  = hdr_d[2];
      w_d[3]  = nonce_ld;
      w_d[4]  = 32'h80000000;
      w_d[15] = 32'd640;
    end
  end

endmodule

// File: tb/tb_bitcoin_nonce_search.sv
// tb/tb_bitcoin_nonce_search.sv - directed bench for bitcoin_nonce_search against a software double-SHA-256 model
module tb_bitcoin_nonce_search;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] IV256 =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        start_w = 1'b0;
  logic [15:0] message_addr = 16'h0000;
  logic [15:0] output_addr = 16'h0100;
  logic [15:0] output_addr_w = 16'hFFFF;
  logic [31:0] target = 32'h0;
  logic [31:0] rd, rd_w;

  logic        done, found, mem_clk, mem_we;
  logic [31:0] found_nonce, mem_write_data;
  logic [15:0] mem_addr;
  logic        done_w, found_w, mem_clk_w, mem_we_w;
  logic [31:0] found_nonce_w, mem_write_data_w;
  logic [15:0] mem_addr_w;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t0 = 0;
  int t0w = 0;

  logic [31:0] mem [65536];
  logic [31:0] hdr [19];
  logic [15:0] wa[$];
  logic [31:0] wd[$];
  int          wc[$];
  logic [15:0] wa_w[$];
  logic [31:0] wd_w[$];

  bitcoin_nonce_search #(.NUM_NONCES(16), .NONCE_BASE(32'h0)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .message_addr(message_addr),
    .output_addr(output_addr), .target(target), .mem_read_data(rd),
    .done(done), .found(found), .found_nonce(found_nonce), .mem_clk(mem_clk),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data)
  );

  bitcoin_nonce_search #(.NUM_NONCES(2), .NONCE_BASE(32'hFFFFFFFF)) u_dut_wrap (
    .clk(clk), .reset_n(reset_n), .start(start_w), .message_addr(message_addr),
    .output_addr(output_addr_w), .target(target), .mem_read_data(rd_w),
    .done(done_w), .found(found_w), .found_nonce(found_nonce_w), .mem_clk(mem_clk_w),
    .mem_we(mem_we_w), .mem_addr(mem_addr_w), .mem_write_data(mem_write_data_w)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    rd   <= mem[mem_addr];
    rd_w <= mem[mem_addr_w];
  end

  always @(posedge clk) begin
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_write_data);
      wc.push_back(cyc - t0);
    end
    if (mem_we_w) begin
      wa_w.push_back(mem_addr_w);
      wd_w.push_back(mem_write_data_w);
    end
  end

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [63:0] y;
    y = {x, x} >> n;
    return y[31:0];
  endfunction

  function automatic logic [255:0] sha_comp(input logic [255:0] s, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, x1, x2;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    {a, b, c, d, e, f, g, h} = s;
    for (int t = 0; t < 64; t++) begin
      x1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
      x2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + x1; d = c; c = b; b = a; a = x1 + x2;
    end
    return {a + s[255:224], b + s[223:192], c + s[191:160], d + s[159:128],
            e + s[127:96],  f + s[95:64],   g + s[63:32],   h + s[31:0]};
  endfunction

  function automatic logic [31:0] exp_h0(input logic [31:0] nonce);
    logic [511:0] b1, b2, b3;
    logic [255:0] mid, dd, hh;
    for (int k = 0; k < 16; k++) b1[511 - 32*k -: 32] = hdr[k];
    mid = sha_comp(IV256, b1);
    b2  = {hdr[16], hdr[17], hdr[18], nonce, 32'h80000000, 320'h0, 32'd640};
    dd  = sha_comp(mid, b2);
    b3  = {dd, 32'h80000000, 192'h0, 32'd256};
    hh  = sha_comp(IV256, b3);
    return hh[255:224];
  endfunction

  task automatic kick();
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int dcyc);
    dcyc = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (done) begin
        dcyc = cyc - t0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done); end
    total++; if (found !== 1'b0) begin bad++; $display("FAIL reset_found got=%0b want=0", found); end
    total++; if (found_nonce !== 32'h0) begin bad++; $display("FAIL reset_found_nonce got=%h want=0", found_nonce); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%0b want=0", mem_we); end
    total++; if (mem_addr !== 16'h0) begin bad++; $display("FAIL reset_mem_addr got=%h want=0", mem_addr); end
    total++; if (mem_write_data !== 32'h0) begin bad++; $display("FAIL reset_mem_wdata got=%h want=0", mem_write_data); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_model();
    logic [255:0] dig;
    dig = sha_comp(IV256, {32'h61626380, 448'h0, 32'h00000018});
    total++;
    if (dig !== 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad) begin
      bad++; $display("FAIL model_abc got=%h", dig);
    end
  endtask

  task automatic test_sweep16(input string tag);
    int dcyc;
    wa.delete(); wd.delete(); wc.delete();
    output_addr = 16'h0100;
    target = 32'h0;
    kick();
    wait_done(3000, dcyc);
    total++; if (dcyc !== 2182) begin bad++; $display("FAIL %s done_cycle got=%0d want=2182", tag, dcyc); end
    total++; if (wa.size() !== 16) begin bad++; $display("FAIL %s write_count got=%0d want=16", tag, wa.size()); end
    for (int i = 0; i < 16 && i < wa.size(); i++) begin
      total++;
      if (wa[i] !== 16'h0100 + i[15:0]) begin
        bad++; $display("FAIL %s addr[%0d] got=%h want=%h", tag, i, wa[i], 16'h0100 + i[15:0]);
      end
      total++;
      if (wd[i] !== exp_h0(i)) begin
        bad++; $display("FAIL %s h0[%0d] got=%h want=%h", tag, i, wd[i], exp_h0(i));
      end
      total++;
      if (wc[i] !== 85 + 131*(i+1)) begin
        bad++; $display("FAIL %s wr_cycle[%0d] got=%0d want=%0d", tag, i, wc[i], 85 + 131*(i+1));
      end
    end
    total++; if (found !== 1'b0) begin bad++; $display("FAIL %s found got=%0b want=0", tag, found); end
    total++; if (found_nonce !== 32'h0) begin bad++; $display("FAIL %s found_nonce got=%h want=0", tag, found_nonce); end
  endtask

  task automatic test_wrap();
    int dcyc;
    wa_w.delete(); wd_w.delete();
    @(negedge clk);
    start_w = 1'b1;
    t0w = cyc;
    @(negedge clk);
    start_w = 1'b0;
    dcyc = -1;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (done_w) begin dcyc = cyc - t0w; break; end
    end
    total++; if (dcyc !== 348) begin bad++; $display("FAIL wrap_done_cycle got=%0d want=348", dcyc); end
    total++; if (wa_w.size() !== 2) begin bad++; $display("FAIL wrap_write_count got=%0d want=2", wa_w.size()); end
    if (wa_w.size() == 2) begin
      total++; if (wa_w[0] !== 16'hFFFF) begin bad++; $display("FAIL wrap_addr0 got=%h want=ffff", wa_w[0]); end
      total++; if (wa_w[1] !== 16'h0000) begin bad++; $display("FAIL wrap_addr1 got=%h want=0000", wa_w[1]); end
      total++; if (wd_w[0] !== exp_h0(32'hFFFFFFFF)) begin
        bad++; $display("FAIL wrap_h0_0 got=%h want=%h", wd_w[0], exp_h0(32'hFFFFFFFF));
      end
      total++; if (wd_w[1] !== exp_h0(32'h0)) begin
        bad++; $display("FAIL wrap_h0_1 got=%h want=%h", wd_w[1], exp_h0(32'h0));
      end
    end
    total++; if (found_w !== 1'b0) begin bad++; $display("FAIL wrap_found got=%0b want=0", found_w); end
  endtask

  task automatic test_reset_mid();
    int nwr;
    wa.delete(); wd.delete(); wc.delete();
    kick();
    repeat (520) @(negedge clk);
    total++; if (wa.size() !== 3) begin bad++; $display("FAIL mid_writes_before got=%0d want=3", wa.size()); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL mid_done got=%0b want=0", done); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL mid_mem_we got=%0b want=0", mem_we); end
    total++; if (mem_addr !== 16'h0) begin bad++; $display("FAIL mid_mem_addr got=%h want=0", mem_addr); end
    total++; if (mem_write_data !== 32'h0) begin bad++; $display("FAIL mid_mem_wdata got=%h want=0", mem_write_data); end
    total++; if (found !== 1'b0 || found_nonce !== 32'h0) begin
      bad++; $display("FAIL mid_found got=%0b/%h want=0/0", found, found_nonce);
    end
    nwr = wa.size();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (400) @(negedge clk);
    total++; if (wa.size() !== nwr) begin bad++; $display("FAIL mid_no_writes got=%0d want=%0d", wa.size(), nwr); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL mid_idle_done got=%0b want=0", done); end
  endtask

  task automatic test_busy_start();
    int dcyc;
    wa.delete(); wd.delete(); wc.delete();
    kick();
    repeat (498) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(3000, dcyc);
    total++; if (dcyc !== 2182) begin bad++; $display("FAIL busy_done_cycle got=%0d want=2182", dcyc); end
    total++; if (wa.size() !== 16) begin bad++; $display("FAIL busy_write_count got=%0d want=16", wa.size()); end
    wa.delete(); wd.delete(); wc.delete();
    kick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL restart_done_clear got=%0b want=0", done); end
    total++; if (mem_addr !== message_addr) begin bad++; $display("FAIL restart_first_addr got=%h want=%h", mem_addr, message_addr); end
    wait_done(3000, dcyc);
    total++; if (dcyc !== 2182) begin bad++; $display("FAIL restart_done_cycle got=%0d want=2182", dcyc); end
    total++; if (wa.size() !== 16) begin bad++; $display("FAIL restart_write_count got=%0d want=16", wa.size()); end
  endtask

  task automatic test_target();
    int dcyc;
    wa.delete(); wd.delete(); wc.delete();
    target = 32'hFFFFFFFF;
    kick();
    wait_done(3000, dcyc);
`ifdef BTC_TARGET_SEARCH_EN
    total++; if (dcyc !== 217) begin bad++; $display("FAIL target_done_cycle got=%0d want=217", dcyc); end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL target_found got=%0b want=1", found); end
    total++; if (found_nonce !== 32'h0) begin bad++; $display("FAIL target_found_nonce got=%h want=0", found_nonce); end
    total++; if (wa.size() !== 1) begin bad++; $display("FAIL target_write_count got=%0d want=1", wa.size()); end
    if (wa.size() > 0) begin
      total++; if (wd[0] !== exp_h0(32'h0)) begin bad++; $display("FAIL target_h0 got=%h want=%h", wd[0], exp_h0(32'h0)); end
    end
`else
    total++; if (dcyc !== 2182) begin bad++; $display("FAIL target_done_cycle got=%0d want=2182", dcyc); end
    total++; if (found !== 1'b0) begin bad++; $display("FAIL target_found got=%0b want=0", found); end
    total++; if (found_nonce !== 32'h0) begin bad++; $display("FAIL target_found_nonce got=%h want=0", found_nonce); end
    total++; if (wa.size() !== 16) begin bad++; $display("FAIL target_write_count got=%0d want=16", wa.size()); end
`endif
    target = 32'h0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 32'h0;
    for (int k = 0; k < 19; k++) begin
      hdr[k] = (32'h9E3779B9 * (k + 1)) ^ (k << 20);
      mem[k] = hdr[k];
    end
    test_reset();
    test_model();
    test_sweep16("sweep");
    test_wrap();
    test_reset_mid();
    test_sweep16("post_reset");
    test_busy_start();
    test_target();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
